x25519_mult_sequencer: RTL and testbench

Control and collection engine that drives one multiplication pass unit through a full 256-bit field multiply mod 2^255-19. It latches operands on a start pulse and issues 32 back-to-back passes with the rotated `b` operand. It collects the 32 partial-sum words, then performs the two-pass carry squeeze serially. The result is presented as a reduced `bignum_t`. It sits between the Curve25519 ladder controller and the pass unit.

---
 rtl/Curve25519Registers.sv | 32 +++
 rtl/x25519_squeeze_serial.sv | 98 +++++++++
 rtl/x25519_mult_sequencer.sv | 138 +++++++++++++
 tb/tb_x25519_mult_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/Curve25519Registers.sv
`default_nettype none
// ============================================================================
// Curve25519Registers : shared types and constants for the x25519 multiplier
// Revision 1.0
// ============================================================================
package Curve25519Registers;

  // 2^255 = 19 (mod p): the carry out of bit 255 folds back as 19x
  localparam int unsigned X25519_P_FOLD = 19;

  typedef logic [31:0][31:0] bignum32_t;

  typedef struct packed {
    bignum32_t blocks;
  } bignum_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    SQ1   = 3'd3,
    SQ2   = 3'd4,
    DONE  = 3'd5
  } x25519_seq_state_t;

  // Limb of b feeding slot j on pass k; the 5-bit wrap gives the mod-32 rotation.
  function automatic logic [4:0] rot_index(input logic [4:0] k, input logic [4:0] j);
    return k - j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/x25519_squeeze_serial.sv
`default_nettype none
// ============================================================================
// x25519_squeeze_serial : 32-word buffer plus two serial carry-squeeze passes
// Revision 1.0
// ============================================================================
module x25519_squeeze_serial
  import Curve25519Registers::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic        pass1_last,
  output logic        done,
  output bignum32_t   words
);

  localparam logic [32:0] FOLD = 33'(X25519_P_FOLD);

  logic        run_q, run_d;
  logic        phase_q, phase_d;
  logic [4:0]  j_q, j_d;
  logic [32:0] u_q, u_d;
  bignum32_t   w_q, w_d;

  logic [32:0] sum;
  logic        last;
  logic [31:0] w_step;
  logic [32:0] u_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      phase_q <= 1'b0;
      j_q     <= '0;
      u_q     <= '0;
      w_q     <= '0;
    end else begin
      run_q   <= run_d;
      phase_q <= phase_d;
      j_q     <= j_d;
      u_q     <= u_d;
      w_q     <= w_d;
    end
  end

  // One limb per cycle; the top limb masks to 7 bits and folds in pass 1,
  // and keeps the full sum in pass 2.
  always_comb begin
    sum    = u_q + {1'b0, w_q[j_q]};
    last   = (j_q == 5'd31);
    w_step = {24'd0, sum[7:0]};
    u_step = {8'd0, sum[32:8]};
    if (last && !phase_q) begin
      w_step = {25'd0, sum[6:0]};
      u_step = FOLD * {7'd0, sum[32:7]};
    end else if (last && phase_q) begin
      w_step = sum[31:0];
      u_step = '0;
    end
  end

  always_comb begin
    run_d   = run_q;
    phase_d = phase_q;
    j_d     = j_q;
    u_d     = u_q;
    w_d     = w_q;
    if (wr_en) begin
      w_d[wr_idx] = wr_data;
    end
    if (start) begin
      run_d   = 1'b1;
      phase_d = 1'b0;
      j_d     = '0;
      u_d     = '0;
    end else if (run_q) begin
      w_d[j_q] = w_step;
      u_d      = u_step;
      j_d      = j_q + 5'd1;
      if (last) begin
        if (phase_q) begin
          run_d = 1'b0;
        end else begin
          phase_d = 1'b1;
        end
      end
    end
  end

  assign pass1_last = run_q && !phase_q && last;
  assign done       = run_q && phase_q && last;
  assign words      = w_q;

endmodule
`default_nettype wire

// File: rtl/x25519_mult_sequencer.sv
`default_nettype none
// ============================================================================
// x25519_mult_sequencer : issues 32 passes, collects words, squeezes mod 2^255-19
// Revision 1.0
// ============================================================================
module x25519_mult_sequencer
  import Curve25519Registers::*;
#(
  parameter int unsigned FLUSH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  bignum_t     a,
  input  bignum_t     b,
  output logic        busy,
  output logic        done,
  output bignum_t     result,
  output logic        mp_en,
  output logic [4:0]  mp_i,
  output bignum_t     mp_a,
  output bignum_t     mp_b,
  input  logic        mp_out_valid,
  input  logic [31:0] mp_out
);

  localparam logic [15:0] FLUSH_INIT = 16'(FLUSH_CYCLES);

  x25519_seq_state_t state_q, state_d;
  logic [15:0]       flush_q, flush_d;
  bignum_t           a_q, a_d;
  bignum_t           b_q, b_d;
  logic [4:0]        k_q, k_d;
  logic [5:0]        c_q, c_d;

  logic      accept;
  logic      capture;
  logic      last_capture;
  logic      sq_start;
  logic      sq_pass1_last;
  logic      sq_done;
  bignum32_t sq_words;

  // The flush lets pass results still in flight from before a reset drain out.
  assign accept       = (state_q == IDLE) && (flush_q == '0) && start;
  assign capture      = ((state_q == ISSUE) || (state_q == DRAIN)) && mp_out_valid
                        && (c_q < 6'd32);
  assign last_capture = capture && (c_q == 6'd31);
  assign sq_start     = (state_q == DRAIN) && last_capture;

  x25519_squeeze_serial u_squeeze (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (capture),
    .wr_idx     (c_q[4:0]),
    .wr_data    (mp_out),
    .start      (sq_start),
    .pass1_last (sq_pass1_last),
    .done       (sq_done),
    .words      (sq_words)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flush_q <= FLUSH_INIT;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = ISSUE;
      ISSUE:   if (k_q == 5'd31)  state_d = DRAIN;
      DRAIN:   if (last_capture)  state_d = SQ1;
      SQ1:     if (sq_pass1_last) state_d = SQ2;
      SQ2:     if (sq_done)       state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_d = flush_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    c_d     = c_q;
    if ((state_q == IDLE) && (flush_q != '0)) begin
      flush_d = flush_q - 16'd1;
    end
    if (accept) begin
      a_d = a;
      b_d = b;
      k_d = '0;
      c_d = '0;
    end
    if (state_q == ISSUE) begin
      k_d = k_q + 5'd1;
    end
    if (capture) begin
      c_d = c_q + 6'd1;
    end
  end

  // The squeeze buffer is only rewritten after the next accepted start,
  // so it doubles as the held result.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    mp_en  = 1'b0;
    mp_i   = '0;
    mp_a   = '0;
    mp_b   = '0;
    result = '{blocks: sq_words};
    if (state_q == ISSUE) begin
      mp_en = 1'b1;
      mp_i  = k_q;
      mp_a  = a_q;
      for (int j = 0; j < 32; j++) begin
        mp_b.blocks[j] = b_q.blocks[rot_index(k_q, 5'(j))];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x25519_mult_sequencer.sv
`default_nettype none
// Directed bench for x25519_mult_sequencer with a latency-5 pass-unit model
// and a NaCl-style reference for the random vectors.
module tb_x25519_mult_sequencer;
  import Curve25519Registers::*;

  localparam int FLUSH = 8;
  localparam int L     = 5;
  localparam int LAT   = L + 97;

  logic    clk   = 1'b0;
  logic    rst   = 1'b1;
  logic    start = 1'b0;
  bignum_t a     = '0;
  bignum_t b     = '0;
  bignum_t result, mp_a, mp_b;
  logic    busy, done, mp_en, mp_out_valid;
  logic [4:0]  mp_i;
  logic [31:0] mp_out;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  bignum_t snap_a, snap_b, junk;
  int      en_first, en_last;
  logic    busy1;

  always #5 clk = ~clk;

  x25519_mult_sequencer #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .mp_en(mp_en), .mp_i(mp_i), .mp_a(mp_a), .mp_b(mp_b),
    .mp_out_valid(mp_out_valid), .mp_out(mp_out)
  );

  // Pass unit: word k of the schoolbook product, high-wrap terms scaled by 38.
  function automatic logic [31:0] pass_word(bignum_t pa, bignum_t pb, logic [4:0] k);
    logic [31:0] s;
    logic [31:0] t;
    s = '0;
    for (int j = 0; j < 32; j++) begin
      t = pa.blocks[j] * pb.blocks[j];
      if (j > int'(k)) t = t * 32'd38;
      s = s + t;
    end
    return s;
  endfunction

  // Not reset: results in flight across a reset still arrive, as in the real unit.
  logic [L-1:0] pv = '0;
  logic [31:0]  pd [L] = '{default: '0};
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mp_en};
    pd[0] <= pass_word(mp_a, mp_b, mp_i);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign mp_out_valid = pv[L-1];
  assign mp_out       = pd[L-1];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mp_en && (mp_i == 5'd0) && (pv != '0)) overlap_cnt++;
  end

  function automatic bignum_t ref_mul(bignum_t x, bignum_t y);
    longint unsigned t [32];
    longint unsigned u, xa, yb;
    bignum_t r;
    for (int i = 0; i < 32; i++) begin
      u = 0;
      for (int j = 0; j < 32; j++) begin
        xa = x.blocks[j];
        if (j <= i) begin
          yb = y.blocks[i-j];
          u += xa * yb;
        end else begin
          yb = y.blocks[i+32-j];
          u += 38 * xa * yb;
        end
      end
      t[i] = u;
    end
    u = 0;
    for (int j = 0; j < 31; j++) begin u += t[j]; t[j] = u & 255; u >>= 8; end
    u += t[31]; t[31] = u & 127; u = 19 * (u >> 7);
    for (int j = 0; j < 31; j++) begin u += t[j]; t[j] = u & 255; u >>= 8; end
    u += t[31]; t[31] = u;
    for (int j = 0; j < 32; j++) r.blocks[j] = t[j][31:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_big(input string tag, input bignum_t obs, input bignum_t exp);
    int k;
    k = 0;
    for (int j = 31; j >= 0; j--) if (obs.blocks[j] !== exp.blocks[j]) k = j;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: limb %0d observed %0h expected %0h", tag, k, obs.blocks[k], exp.blocks[k]);
    end
  endtask

  // Drives start in the current cycle; p1/p2 inject ignored starts with junk operands.
  task automatic run_op(input bignum_t oa, input bignum_t ob, input int p1, input int p2,
                        output bignum_t res, output int lat);
    a = oa; b = ob; start = 1'b1;
    lat = -1; res = '0; en_first = -1; en_last = -1; busy1 = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == p1 || n == p2) begin
        start = 1'b1; a = junk; b = junk;
      end else begin
        start = 1'b0; a = '0; b = '0;
      end
      if (n == 1) busy1 = busy;
      if (mp_en) begin
        if (en_first < 0) en_first = n;
        en_last = n;
        if (mp_i == 5'd5) begin snap_a = mp_a; snap_b = mp_b; end
      end
      if (done) begin lat = n; res = result; break; end
    end
    start = 1'b0;
    chk("done_seen", {63'd0, lat >= 0}, 64'd1);
  endtask

  function automatic bignum_t rand_big();
    bignum_t r;
    for (int j = 0; j < 32; j++) r.blocks[j] = 32'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    bignum_t x, y, e, r, r2, x2, y2;
    int lat, cnt, dc0;
    logic hit;
    for (int j = 0; j < 32; j++) junk.blocks[j] = 32'hAB;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_mp_en", {63'd0, mp_en}, 64'd0);
    chk("rst_mp_i", {59'd0, mp_i}, 64'd0);
    chk_big("rst_result", result, '0);
    chk_big("rst_mp_a", mp_a, '0);
    chk_big("rst_mp_b", mp_b, '0);
    rst = 1'b0;
    repeat (FLUSH + 2) @(negedge clk);

    // Identity, plus issue window and operand rotation
    x = '0; y = '0; x.blocks[0] = 1; y.blocks[0] = 1;
    run_op(x, y, 0, 0, r, lat);
    e = '0; e.blocks[0] = 1;
    chk_big("identity", r, e);
    chk("identity_latency", 64'(lat), 64'(LAT));
    chk("busy_cycle1", {63'd0, busy1}, 64'd1);
    chk("mp_en_first", 64'(en_first), 64'd1);
    chk("mp_en_last", 64'(en_last), 64'd32);
    chk_big("mp_a_k5", snap_a, x);
    e = '0; e.blocks[5] = 1;
    chk_big("mp_b_k5", snap_b, e);
    @(negedge clk);
    chk("done_width", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("mp_en_after", {63'd0, mp_en}, 64'd0);
    chk_big("mp_b_after", mp_b, '0);
    e = '0; e.blocks[0] = 1;
    chk_big("result_hold", result, e);

    // Wrap fold: 2 * 2^255 -> 38
    x = '0; y = '0; x.blocks[0] = 2; y.blocks[31] = 128;
    run_op(x, y, 0, 0, r, lat);
    e = '0; e.blocks[0] = 38;
    chk_big("wrap_fold", r, e);
    @(negedge clk);

    // 255*255 = 0xFE01: carry into limb 1
    x = '0; y = '0; x.blocks[0] = 255; y.blocks[0] = 255;
    run_op(x, y, 0, 0, r, lat);
    e = '0; e.blocks[0] = 1; e.blocks[1] = 254;
    chk_big("carry_255sq", r, e);
    @(negedge clk);

    // 2^8 * 2^255 -> 19 * 2^8
    x = '0; y = '0; x.blocks[1] = 1; y.blocks[31] = 128;
    run_op(x, y, 0, 0, r, lat);
    e = '0; e.blocks[1] = 19;
    chk_big("fold_limb1", r, e);
    @(negedge clk);

    // Random 8-bit-limb vectors against the reference
    for (int v = 0; v < 200; v++) begin
      x = rand_big(); y = rand_big();
      run_op(x, y, 0, 0, r, lat);
      chk_big($sformatf("random_%0d", v), r, ref_mul(x, y));
      if (v == 0) begin
        for (int j = 0; j < 32; j++) e.blocks[j] = y.blocks[(5 - j + 32) % 32];
        chk_big("mp_b_rot_random", snap_b, e);
      end
      @(negedge clk);
    end

    // Starts during ISSUE and SQ1 are dropped
    dc0 = done_cnt;
    x = '0; y = '0; x.blocks[0] = 3; y.blocks[0] = 5;
    run_op(x, y, 10, 50, r, lat);
    e = '0; e.blocks[0] = 15;
    chk_big("busy_drop", r, e);
    repeat (120) @(negedge clk);
    chk("busy_drop_done_count", 64'(done_cnt - dc0), 64'd1);
    chk_big("busy_drop_hold", result, e);
    chk("busy_drop_idle", {63'd0, busy}, 64'd0);

    // Reset during ISSUE at k=10, start held on every cycle after release
    a = junk; b = junk; start = 1'b1; hit = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (mp_en && (mp_i == 5'd10)) begin hit = 1'b1; break; end
    end
    chk("abort_reached_k10", {63'd0, hit}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_mp_en", {63'd0, mp_en}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    x = rand_big(); y = rand_big();
    rst = 1'b0; a = x; b = y; start = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      cnt++;
      if (busy) break;
    end
    chk("flush_accept_cycle", 64'(cnt), 64'(FLUSH + 1));
    a = junk; b = junk;
    lat = -1;
    for (int n = 2; n <= 300; n++) begin
      @(negedge clk);
      if (done) begin lat = n; r = result; start = 1'b0; break; end
    end
    start = 1'b0;
    chk("abort_latency", 64'(lat), 64'(LAT));
    chk_big("abort_result", r, ref_mul(x, y));
    @(negedge clk);

    // Back-to-back: second start in the cycle busy falls
    x = rand_big(); y = rand_big(); x2 = rand_big(); y2 = rand_big();
    run_op(x, y, 0, 0, r, lat);
    @(negedge clk);
    chk("b2b_busy_fell", {63'd0, busy}, 64'd0);
    run_op(x2, y2, 0, 0, r2, lat);
    chk("b2b_accepted", {63'd0, busy1}, 64'd1);
    chk_big("b2b_first", r, ref_mul(x, y));
    chk_big("b2b_second", r2, ref_mul(x2, y2));
    chk("b2b_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("issue_overlap", 64'(overlap_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
